// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller (package lib_intr).
// Used by intr_ctrl and by any block that decodes its cause output.
package lib_intr;

  localparam int N_SRC     = 4;
  localparam int TIMER_SRC = 3;

  typedef logic [1:0] cause_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Bit 0 has the highest priority, so scan from the top down and let the
  // lowest set bit win.
  function automatic cause_t lowest_set(input logic [N_SRC-1:0] flags);
    cause_t idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (flags[i]) idx = cause_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_timer.sv
// Periodic tick source: down-counter from TIMER_PERIOD-1 to 0, one-cycle tick at 0.
// Instantiated by intr_ctrl only when INTR_TIMER_EN is defined.
module intr_timer #(
  parameter logic [15:0] TIMER_PERIOD = 16'd1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [15:0] count;

  assign tick = (count == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= TIMER_PERIOD - 16'd1;
    end else if (tick) begin
      count <= TIMER_PERIOD - 16'd1;
    end else begin
      count <= count - 16'd1;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-capturing interrupt controller that injects an icall into the CPU stream.
// Optional macro INTR_TIMER_EN: an internal periodic timer drives source 3.
module intr_ctrl
  import lib_intr::*;
#(
  parameter logic [15:0] TIMER_PERIOD = 16'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             intr_en,
  input  logic             icall_taken,
  input  logic             ack,
  output logic             icall_req,
  output cause_t           cause,
  output logic [N_SRC-1:0] pending,
  output logic             busy
);

  if (TIMER_PERIOD < 16'd2) begin : g_period_check
    $error("intr_ctrl: TIMER_PERIOD must be at least 2");
  end

  state_t           state;
  state_t           next_state;
  logic [N_SRC-1:0] irq_prev;
  logic             armed;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] set_mask;
  logic [N_SRC-1:0] clr_mask;
  logic             load_cause;

  // armed stays low for the first edge after reset so a line already high at
  // reset release is absorbed into irq_prev instead of reading as a rising edge.
  assign rise = armed ? (irq_in & ~irq_prev) : '0;

`ifdef INTR_TIMER_EN
  logic timer_tick;

  intr_timer #(
    .TIMER_PERIOD (TIMER_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (timer_tick)
  );

  always_comb begin
    set_mask            = rise;
    set_mask[TIMER_SRC] = timer_tick;
  end
`else
  assign set_mask = rise;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    next_state = state;
    load_cause = 1'b0;
    clr_mask   = '0;
    case (state)
      IDLE: begin
        if ((|pending) && intr_en) begin
          next_state = REQ;
          load_cause = 1'b1;
        end
      end
      REQ: begin
        if (icall_taken) begin
          next_state      = SERVICE;
          clr_mask[cause] = 1'b1;
        end else if (!intr_en) begin
          next_state = IDLE;
        end
      end
      SERVICE: begin
        if (ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      icall_req <= 1'b0;
      cause     <= '0;
      pending   <= '0;
      irq_prev  <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= next_state;
      icall_req <= (next_state == REQ);
      irq_prev  <= irq_in;
      armed     <= 1'b1;
      // Set wins over clear so an edge landing in the icall_taken cycle is kept.
      pending   <= (pending & ~clr_mask) | set_mask;
      if (load_cause) cause <= lowest_set(pending);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl; the timer scenario runs when
// INTR_TIMER_EN is defined, the peripheral-source scenarios otherwise.
module tb_intr_ctrl;
  import lib_intr::*;

  localparam logic [15:0] TP = 16'd10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       intr_en;
  logic       icall_taken;
  logic       ack;
  logic       icall_req;
  cause_t     cause;
  logic [3:0] pending;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  intr_ctrl #(
    .TIMER_PERIOD (TP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .intr_en     (intr_en),
    .icall_taken (icall_taken),
    .ack         (ack),
    .icall_req   (icall_req),
    .cause       (cause),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; irq_in = '0; intr_en = 1'b0; icall_taken = 1'b0; ack = 1'b0;
    #2;
    n_checks++; if (icall_req !== 1'b0) begin n_fail++; $display("FAIL reset_icall_req: got %b want 0", icall_req); end
    n_checks++; if (cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %0d want 0", cause); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    cyc(2);
    reset = 1'b0;
    cyc(1);
    n_checks++; if (pending !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: pending %b busy %b want 0000/0", pending, busy); end
  endtask

  task automatic test_basic;
    intr_en = 1'b1; irq_in = 4'b0010;
    cyc(1);
    n_checks++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL basic_capture: pending %b want 0010", pending); end
    n_checks++; if (icall_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_early: icall_req %b want 0", icall_req); end
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_req: icall_req %b cause %0d busy %b want 1/1/1", icall_req, cause, busy); end
    icall_taken = 1'b1;
    cyc(1);
    icall_taken = 1'b0;
    n_checks++; if (pending !== 4'b0000 || busy !== 1'b1 || icall_req !== 1'b0) begin n_fail++; $display("FAIL basic_taken: pending %b busy %b icall_req %b want 0000/1/0", pending, busy, icall_req); end
    cyc(2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_wait_ack: busy %b want 1", busy); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_ack: busy %b want 0", busy); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    n_checks++; if (busy !== 1'b0 || icall_req !== 1'b0 || cause !== 2'd1) begin n_fail++; $display("FAIL idle_ack_ignored: busy %b icall_req %b cause %0d want 0/0/1", busy, icall_req, cause); end
    irq_in = '0;
    cyc(1);
  endtask

  task automatic test_priority;
    irq_in = 4'b0101;
    cyc(1);
    n_checks++; if (pending !== 4'b0101) begin n_fail++; $display("FAIL prio_capture: pending %b want 0101", pending); end
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd0) begin n_fail++; $display("FAIL prio_first: icall_req %b cause %0d want 1/0", icall_req, cause); end
    icall_taken = 1'b1;
    cyc(1);
    icall_taken = 1'b0;
    n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL prio_clear0: pending %b want 0100", pending); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_idle: busy %b want 0", busy); end
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd2) begin n_fail++; $display("FAIL prio_second: icall_req %b cause %0d want 1/2", icall_req, cause); end
    icall_taken = 1'b1; cyc(1); icall_taken = 1'b0;
    ack = 1'b1; cyc(1); ack = 1'b0;
    irq_in = '0;
    cyc(1);
    n_checks++; if (pending !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_done: pending %b busy %b want 0000/0", pending, busy); end
  endtask

  task automatic test_masking;
    bit stray;
    stray = 1'b0;
    intr_en = 1'b0; irq_in = 4'b0100;
    cyc(1);
    n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL mask_capture: pending %b want 0100", pending); end
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (icall_req !== 1'b0) stray = 1'b1;
    end
    n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL mask_hold: icall_req rose while masked, want 0 for 20 cycles"); end
    intr_en = 1'b1;
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd2) begin n_fail++; $display("FAIL mask_release: icall_req %b cause %0d want 1/2", icall_req, cause); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    n_checks++; if (icall_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL req_ack_ignored: icall_req %b busy %b want 1/1", icall_req, busy); end
    icall_taken = 1'b1; cyc(1); icall_taken = 1'b0;
    ack = 1'b1; cyc(1); ack = 1'b0;
    irq_in = '0;
    cyc(1);
  endtask

  task automatic test_cancel;
    intr_en = 1'b1; irq_in = 4'b0010;
    cyc(2);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd1) begin n_fail++; $display("FAIL cancel_req: icall_req %b cause %0d want 1/1", icall_req, cause); end
    intr_en = 1'b0; irq_in = '0;
    cyc(1);
    n_checks++; if (icall_req !== 1'b0 || busy !== 1'b0 || pending !== 4'b0010 || cause !== 2'd1) begin n_fail++; $display("FAIL cancel: icall_req %b busy %b pending %b cause %0d want 0/0/0010/1", icall_req, busy, pending, cause); end
    intr_en = 1'b1;
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd1) begin n_fail++; $display("FAIL cancel_rerequest: icall_req %b cause %0d want 1/1", icall_req, cause); end
    irq_in = 4'b0010; icall_taken = 1'b1;
    cyc(1);
    icall_taken = 1'b0;
    n_checks++; if (pending !== 4'b0010 || busy !== 1'b1) begin n_fail++; $display("FAIL set_over_clear: pending %b busy %b want 0010/1", pending, busy); end
    ack = 1'b1; cyc(1); ack = 1'b0;
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd1) begin n_fail++; $display("FAIL merged_redispatch: icall_req %b cause %0d want 1/1", icall_req, cause); end
    icall_taken = 1'b1; cyc(1); icall_taken = 1'b0;
    ack = 1'b1; cyc(1); ack = 1'b0;
    irq_in = '0;
    cyc(1);
    n_checks++; if (pending !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL cancel_done: pending %b busy %b want 0000/0", pending, busy); end
  endtask

  task automatic test_reset_mid;
    intr_en = 1'b1; irq_in = 4'b0010;
    cyc(2);
    icall_taken = 1'b1; cyc(1); icall_taken = 1'b0;
    irq_in = 4'b0011;
    cyc(1);
    n_checks++; if (busy !== 1'b1 || pending !== 4'b0001 || cause !== 2'd1) begin n_fail++; $display("FAIL rst_setup: busy %b pending %b cause %0d want 1/0001/1", busy, pending, cause); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || icall_req !== 1'b0 || pending !== 4'b0000 || cause !== 2'd0) begin n_fail++; $display("FAIL rst_async: busy %b icall_req %b pending %b cause %0d want 0/0/0000/0", busy, icall_req, pending, cause); end
    irq_in = 4'b0001;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    n_checks++; if (pending !== 4'b0000 || icall_req !== 1'b0) begin n_fail++; $display("FAIL rst_held_line: pending %b icall_req %b want 0000/0", pending, icall_req); end
    irq_in = '0; cyc(1);
    irq_in = 4'b0001; cyc(1);
    n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL rst_fresh_edge: pending %b want 0001", pending); end
    cyc(1);
    icall_taken = 1'b1; cyc(1); icall_taken = 1'b0;
    ack = 1'b1; cyc(1); ack = 1'b0;
    irq_in = '0;
    cyc(1);
  endtask

  task automatic test_source3;
    intr_en = 1'b1; irq_in = 4'b1000;
    cyc(1);
    n_checks++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL src3_capture: pending %b want 1000", pending); end
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd3) begin n_fail++; $display("FAIL src3_req: icall_req %b cause %0d want 1/3", icall_req, cause); end
    icall_taken = 1'b1; cyc(1); icall_taken = 1'b0;
    ack = 1'b1; cyc(1); ack = 1'b0;
    irq_in = '0;
    cyc(1);
  endtask

  task automatic test_timer;
    bit early;
    early = 1'b0;
    intr_en = 1'b0; irq_in = '0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      irq_in[3] = e[0];
      cyc(1);
      if (pending !== 4'b0000) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL timer_early: pending set before period or by irq_in[3]"); end
    cyc(1);
    n_checks++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL timer_first_tick: pending %b want 1000", pending); end
    intr_en = 1'b1;
    cyc(1);
    n_checks++; if (icall_req !== 1'b1 || cause !== 2'd3) begin n_fail++; $display("FAIL timer_req: icall_req %b cause %0d want 1/3", icall_req, cause); end
    icall_taken = 1'b1; cyc(1); icall_taken = 1'b0;
    ack = 1'b1; cyc(1); ack = 1'b0;
    early = 1'b0;
    for (int e = 14; e <= 19; e++) begin
      irq_in[3] = e[0];
      cyc(1);
      if (pending[3] !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL timer_gap: pending[3] set inside period"); end
    cyc(1);
    n_checks++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL timer_second_tick: pending[3] %b want 1", pending[3]); end
  endtask

  initial begin
    test_reset();
`ifdef INTR_TIMER_EN
    test_timer();
`else
    test_basic();
    test_priority();
    test_masking();
    test_cancel();
    test_reset_mid();
    test_source3();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter: TIMER_PERIOD, 16'd1000, cycles between timer interrupts (legal range 2..65535).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: irq_in  input  4  peripheral interrupt lines, level; rising edges are captured.
REQ-005 Port: intr_en  input  1  CPU interrupt-enable status register bit.
REQ-006 Port: icall_taken  input  1  one-cycle pulse when the CPU executes the injected icall.
REQ-007 Port: ack  input  1  one-cycle pulse from the CPU interrupt-acknowledge write.
REQ-008 Port: icall_req  output  1  request to the decoder to substitute icall for the next instruction.
REQ-009 Port: cause  output  2  index of the source being requested or serviced.
REQ-010 Port: pending  output  4  latched, not-yet-dispatched interrupt flags.
REQ-011 Port: busy  output  1  high in states REQ and SERVICE.

Function
REQ-012 Edge capture SHALL register irq_in each cycle; bit i rising (prev 0, now 1) sets pending[i] at that clock edge.
REQ-013 The state machine SHALL have three states: IDLE, REQ, SERVICE.
REQ-014 IDLE -> REQ when pending != 0 and intr_en = 1; cause latches the lowest set pending index (bit 0 highest priority).
REQ-015 icall_req SHALL be registered, high exactly while in REQ; latency from the capturing edge to icall_req high is one cycle.
REQ-016 REQ -> SERVICE on icall_taken; pending[cause] clears on the same edge.
REQ-017 REQ -> IDLE if intr_en = 0 and icall_taken = 0 (cancel); pending is kept; cause is not cleared.
REQ-018 SERVICE -> IDLE on ack; ack in IDLE or REQ SHALL be ignored.
REQ-019 cause SHALL hold stable from REQ entry until the next IDLE -> REQ transition.
REQ-020 New edges SHALL set pending in any state; a set and a clear of the same bit on one edge leave the bit set.
REQ-021 Additional edges on an already-pending source SHALL be merged (no counting).
REQ-022 Nesting SHALL NOT occur: a new request is issued only from IDLE.

Reset
REQ-023 Reset SHALL asynchronously force state IDLE, icall_req 0, cause 0, pending 0, busy 0, edge registers 0, timer counter TIMER_PERIOD-1.
REQ-024 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the interrupt without waiting for icall_taken or ack.
REQ-025 A line held high through reset release SHALL NOT produce an edge.

Configuration
REQ-026 Macro INTR_TIMER_EN defined: an internal 16-bit down-counter runs from TIMER_PERIOD-1 to 0, and reaching 0 reloads it and sets pending[3]; irq_in[3] is ignored.
REQ-027 INTR_TIMER_EN undefined: no counter is built; pending[3] comes from irq_in[3] edges like the other sources.

Structure
REQ-028 A shared package lib_intr SHALL hold the state enum (IDLE, REQ, SERVICE), N_SRC = 4, the cause typedef (logic [1:0]), and TIMER_SRC = 3.
REQ-029 The timer SHALL be the sub-module intr_timer (clk, reset, tick out), instantiated only under INTR_TIMER_EN.

Verification
REQ-030 Basic: irq_in[1] rises, intr_en = 1 -> pending = 4'b0010 after the capturing edge; icall_req = 1 and cause = 1 on the next cycle; icall_taken -> pending = 0, busy = 1; ack -> IDLE, busy = 0.
REQ-031 Priority: irq_in[2] and irq_in[0] rise together -> cause = 0 first; after ack, cause = 2 is requested, with no extra edge needed.
REQ-032 Masking: pending = 4'b0100 with intr_en = 0 -> icall_req stays 0 for 20 cycles; intr_en raised -> icall_req = 1 one cycle later.
REQ-033 Cancel and re-edge: intr_en drops in REQ -> return to IDLE with pending kept; an edge on the source being cleared in the icall_taken cycle -> pending bit stays 1.
REQ-034 Reset: reset pulsed in SERVICE -> all outputs 0 immediately, before the clock edge; irq_in[0] held high across reset release -> pending stays 0.
REQ-035 Timer (INTR_TIMER_EN, TIMER_PERIOD = 10) -> pending[3] sets every 10 cycles after reset; irq_in[3] toggling has no effect.
